// File: rtl/project_3_no_auto_pkg.sv
// Shared types and constants for the T-bird taillight controller:
// state enum, HEX5 glyphs and the inner-first lamp sequence table.
package taillight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HZRD,
    ST_SIG_L,
    ST_SIG_R,
    ST_BRK,
    ST_BRK_SIG_L,
    ST_BRK_SIG_R
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] HEX_IDLE      = 8'hBF;
  localparam logic [7:0] HEX_HZRD      = 8'h89;
  localparam logic [7:0] HEX_SIG_L     = 8'hC7;
  localparam logic [7:0] HEX_SIG_R     = 8'hAF;
  localparam logic [7:0] HEX_BRK       = 8'h83;
  localparam logic [7:0] HEX_BRK_SIG_L = 8'h47;
  localparam logic [7:0] HEX_BRK_SIG_R = 8'h2F;

  // Indexed by phase; bit 0 is the inner lamp.
  localparam logic [3:0][2:0] SEQ_PAT = {3'b111, 3'b011, 3'b001, 3'b000};

  function automatic logic [7:0] hex_glyph(input state_t s);
    case (s)
      ST_HZRD:      return HEX_HZRD;
      ST_SIG_L:     return HEX_SIG_L;
      ST_SIG_R:     return HEX_SIG_R;
      ST_BRK:       return HEX_BRK;
      ST_BRK_SIG_L: return HEX_BRK_SIG_L;
      ST_BRK_SIG_R: return HEX_BRK_SIG_R;
      default:      return HEX_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/project_3_no_auto_if.sv
// Board-side signal bundle for the taillight controller (keys, switches,
// LEDs, HEX5); master drives the board inputs, slave is the controller.
interface project_3_no_auto_if;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [7:0] HEX5;

  modport master (output KEY, SW, input LEDR, HEX5);
  modport slave  (input KEY, SW, output LEDR, HEX5);
endinterface

// File: rtl/project_3_no_auto_step_tick_gen.sv
// Step tick divider: one-clock tick every TICK_DIV clocks; clr restarts the
// count and suppresses the tick in that cycle.
module step_tick_gen #(
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = !clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/project_3_no_auto.sv
// DE10-Lite sequential taillight controller (top). Optional macro
// INPUT_SYNC_EN adds a 2-flop synchronizer on SW[2:0] and KEY[1].
module project_3_no_auto
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic       ADC_CLK_10,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [7:0] HEX5
);

  logic       w_rst_n;
  logic [3:0] w_in;       // {KEY1, SW2, SW1, SW0}
  logic       w_unused;

  assign w_rst_n  = KEY[0];
  assign w_unused = ^SW[9:3];

`ifdef INPUT_SYNC_EN
  logic [3:0] r_sync1, r_sync2;

  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= 4'b1000;
      r_sync2 <= 4'b1000;
    end else begin
      r_sync1 <= {KEY[1], SW[2:0]};
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = {KEY[1], SW[2:0]};
`endif

  state_t     r_state, w_next;
  logic [1:0] r_phase, w_phase_nxt;
  logic [9:0] r_ledr, w_ledr;
  logic [7:0] r_hex;
  logic       w_chg, w_tick;
  logic [2:0] w_pat, w_left, w_right;

  always_comb begin
    w_next = ST_IDLE;
    if (w_in[0])               w_next = ST_HZRD;
    else if (w_in[2] && w_in[1]) w_next = w_in[3] ? ST_BRK_SIG_L : ST_BRK_SIG_R;
    else if (w_in[1])          w_next = w_in[3] ? ST_SIG_L : ST_SIG_R;
    else if (w_in[2])          w_next = ST_BRK;
  end

  assign w_chg = (w_next != r_state);

  step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (ADC_CLK_10),
    .rst_n (w_rst_n),
    .clr   (w_chg),
    .tick  (w_tick)
  );

  // Outputs are computed from next-state/next-phase so LEDR lands with the state.
  always_comb begin
    w_phase_nxt = r_phase;
    if (w_chg)       w_phase_nxt = '0;
    else if (w_tick) w_phase_nxt = r_phase + 1'b1;
    w_pat   = SEQ_PAT[w_phase_nxt];
    w_left  = w_pat;
    w_right = {w_pat[0], w_pat[1], w_pat[2]};
    w_ledr  = '0;
    case (w_next)
      ST_HZRD:      w_ledr = {{3{w_phase_nxt[0]}}, 4'b0000, {3{w_phase_nxt[0]}}};
      ST_SIG_L:     w_ledr = {w_left, 7'b0000000};
      ST_SIG_R:     w_ledr = {7'b0000000, w_right};
      ST_BRK:       w_ledr = 10'h387;
      ST_BRK_SIG_L: w_ledr = {w_left, 4'b0000, 3'b111};
      ST_BRK_SIG_R: w_ledr = {3'b111, 4'b0000, w_right};
      default:      w_ledr = '0;
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_ledr  <= '0;
      r_hex   <= HEX_IDLE;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_nxt;
      r_ledr  <= w_ledr;
      r_hex   <= hex_glyph(w_next);
    end
  end

  assign LEDR = r_ledr;
  assign HEX5 = r_hex;

endmodule

// File: tb/tb_project_3_no_auto.sv
// Scoreboard bench for project_3_no_auto: a state/age reference model pushes
// expected LEDR/HEX5 values, a monitor process pops and compares them.
module tb_project_3_no_auto;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  project_3_no_auto_if bus ();

  project_3_no_auto #(.TICK_DIV(TD)) dut (
    .ADC_CLK_10 (clk),
    .KEY        (bus.KEY),
    .SW         (bus.SW),
    .LEDR       (bus.LEDR),
    .HEX5       (bus.HEX5)
  );

  typedef struct {
    logic [9:0] ledr;
    logic [7:0] hex;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  event ev_chk;
  int   total = 0;
  int   bad   = 0;

  // Reference model: state code (0 idle,1 hzrd,2 sig_l,3 sig_r,4 brk,5 brk_sig_l,6 brk_sig_r)
  // and number of clocks spent in that state.
  int         m_state;
  int         m_age;
  logic [3:0] m_pipe0, m_pipe1;

  function automatic int decode(input logic [3:0] in);
    if (in[0])          return 1;
    if (in[2] && in[1]) return in[3] ? 5 : 6;
    if (in[1])          return in[3] ? 2 : 3;
    if (in[2])          return 4;
    return 0;
  endfunction

  function automatic logic [9:0] exp_ledr(input int st, input int age);
    int ph;
    logic [9:0] l, r;
    ph = (age / TD) % 4;
    l = '0;
    r = '0;
    for (int i = 0; i < ph; i++) begin
      l[7 + i] = 1'b1;
      r[2 - i] = 1'b1;
    end
    case (st)
      1:       return (ph % 2 == 1) ? 10'h387 : 10'h000;
      2:       return l;
      3:       return r;
      4:       return 10'h387;
      5:       return l | 10'h007;
      6:       return r | 10'h380;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [7:0] exp_hex(input int st);
    case (st)
      1:       return 8'h89;
      2:       return 8'hC7;
      3:       return 8'hAF;
      4:       return 8'h83;
      5:       return 8'h47;
      6:       return 8'h2F;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_age   = 0;
    m_pipe0 = 4'b1000;
    m_pipe1 = 4'b1000;
  endtask

  task automatic model_clock(input logic [3:0] cur);
    logic [3:0] eff;
    int s;
`ifdef INPUT_SYNC_EN
    eff     = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = cur;
`else
    eff = cur;
`endif
    s = decode(eff);
    if (s != m_state) begin
      m_state = s;
      m_age   = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.ledr = exp_ledr(m_state, m_age);
    e.hex  = exp_hex(m_state);
    e.tag  = tag;
    exp_q.push_back(e);
    -> ev_chk;
  endtask

  // One clock of stimulus: inputs change on the falling edge, checks land 1 time unit
  // after the falling edge (reset only) and 1 after the rising edge.
  task automatic step(input logic [2:0] sw, input logic key1, input logic key0, input string tag);
    @(negedge clk);
    bus.SW  = {7'($urandom), sw};
    bus.KEY = {key1, key0};
    if (!key0) begin
      model_reset();
      #1 push({tag, "_async"});
    end
    @(posedge clk);
    if (key0) model_clock({key1, sw});
    #1 push(tag);
  endtask

  task automatic hold(input logic [2:0] sw, input logic key1, input int n, input string tag);
    for (int i = 0; i < n; i++) step(sw, key1, 1'b1, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_chk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (bus.LEDR !== e.ledr || bus.HEX5 !== e.hex) begin
          bad++;
          $display("FAIL %s: got LEDR=%h HEX5=%h, want LEDR=%h HEX5=%h at %0t",
                   e.tag, bus.LEDR, bus.HEX5, e.ledr, e.hex, $time);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    bus.KEY = 2'b10;
    bus.SW  = '0;
    model_reset();

    for (int i = 0; i < 3; i++) step(3'($urandom), 1'($urandom), 1'b0, "reset_any_sw");
    hold(3'b000, 1'b1, 4,  "idle");
    hold(3'b001, 1'b1, 20, "hazard");
    hold(3'b010, 1'b1, 20, "sig_left");
    hold(3'b010, 1'b0, 20, "sig_right_flip");
    hold(3'b100, 1'b1, 8,  "brake");
    hold(3'b110, 1'b1, 20, "brk_sig_left");
    hold(3'b110, 1'b0, 20, "brk_sig_right");
    hold(3'b111, 1'b1, 10, "priority_all");
    hold(3'b000, 1'b1, 4,  "idle2");
    hold(3'b010, 1'b1, 11, "sig_to_phase2");
    step(3'b010, 1'b1, 1'b0, "reset_mid_seq");
    step(3'b010, 1'b1, 1'b0, "reset_mid_seq");
    hold(3'b010, 1'b1, 20, "restart_after_reset");

    for (int unsigned seg = 0; seg < 40; seg++) begin
      n = int'($urandom_range(12, 1));
      if ($urandom_range(15, 0) == 0) begin
        for (int i = 0; i < 2; i++) step(3'($urandom), 1'($urandom), 1'b0, "rand_reset");
      end else begin
        hold(3'($urandom), 1'($urandom), n, "random");
      end
    end

    begin : drain
      int unsigned budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
